// File: rtl/riscv_rf_pkg.sv
`default_nettype none
// ============================================================================
// Module      : riscv_rf_pkg
// Description : Shared types and constants for the register file port
//               sequencer: data/index widths, FSM state encoding and the
//               index zero-extension helper.
// Revision    : 1.0 - initial release
// ============================================================================
package riscv_rf_pkg;

    localparam int XLEN = 32;
    localparam int AW   = 5;

    // Port sequencer states: idle/writeback, read rs1, read rs2, present operands
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RD1   = 2'd1,
        RD2   = 2'd2,
        VALID = 2'd3
    } state_e;

    // Zero-extend a register index onto the 32-bit register file index bus
    function automatic logic [31:0] zext_idx(input logic [AW-1:0] idx);
        return {{(32-AW){1'b0}}, idx};
    endfunction

endpackage
`default_nettype wire

// File: rtl/regfile_port_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : regfile_port_sequencer
// Description : Owns the single port of the register file. Splits a
//               two-operand read request into two back-to-back port reads,
//               slots writebacks into idle port cycles and hands both
//               operands to execute under a valid/ready handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_port_sequencer
    import riscv_rf_pkg::state_e;
    import riscv_rf_pkg::IDLE;
    import riscv_rf_pkg::RD1;
    import riscv_rf_pkg::RD2;
    import riscv_rf_pkg::VALID;
#(
    parameter int XLEN = riscv_rf_pkg::XLEN,
    parameter int AW   = riscv_rf_pkg::AW
) (
    input  logic            clk,
    input  logic            rst,            // asynchronous, active low
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [AW-1:0]   req_rs1,
    input  logic [AW-1:0]   req_rs2,
    output logic            op_valid,
    input  logic            op_ready,
    output logic [XLEN-1:0] op_a,
    output logic [XLEN-1:0] op_b,
    input  logic            wb_valid,
    output logic            wb_ready,
    input  logic [AW-1:0]   wb_rd,
    input  logic [XLEN-1:0] wb_data,
    output logic [31:0]     rf_register,
    output logic            rf_write_enable,
    output logic [XLEN-1:0] rf_write_data,
    input  logic [XLEN-1:0] rf_read_data
);

    state_e          state_q, state_d;
    logic [AW-1:0]   rs1_q, rs1_d;
    logic [AW-1:0]   rs2_q, rs2_d;
    logic [XLEN-1:0] op_a_q, op_a_d;
    logic [XLEN-1:0] op_b_q, op_b_d;

    logic            w_req_ready;
    logic            w_wb_ready;
    logic [AW-1:0]   w_port_idx;
    logic            w_port_we;
    logic [XLEN-1:0] w_port_wdata;

    // Next-state and port control: writeback wins the port whenever it is free
    always_comb begin
        state_d      = state_q;
        rs1_d        = rs1_q;
        rs2_d        = rs2_q;
        op_a_d       = op_a_q;
        op_b_d       = op_b_q;
        w_req_ready  = 1'b0;
        w_wb_ready   = 1'b0;
        w_port_idx   = '0;
        w_port_we    = 1'b0;
        w_port_wdata = '0;

        case (state_q)
            IDLE: begin
                if (wb_valid) begin
                    w_wb_ready   = 1'b1;
                    w_port_idx   = wb_rd;
                    w_port_wdata = wb_data;
                    w_port_we    = (wb_rd != '0);
                end else if (req_valid) begin
                    w_req_ready = 1'b1;
                    rs1_d       = req_rs1;
                    rs2_d       = req_rs2;
                    state_d     = RD1;
                end
            end
            RD1: begin
                w_port_idx = rs1_q;
                op_a_d     = rf_read_data;
                state_d    = RD2;
            end
            RD2: begin
                w_port_idx = rs2_q;
                op_b_d     = rf_read_data;
                state_d    = VALID;
            end
            VALID: begin
                // Operands are held in flops, so the port is free for writebacks
                if (wb_valid) begin
                    w_wb_ready   = 1'b1;
                    w_port_idx   = wb_rd;
                    w_port_wdata = wb_data;
                    w_port_we    = (wb_rd != '0);
                end
                if (op_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Drive outputs; reset asserted forces the whole port quiet immediately
    always_comb begin
        req_ready       = 1'b0;
        wb_ready        = 1'b0;
        rf_register     = '0;
        rf_write_enable = 1'b0;
        rf_write_data   = '0;
        if (rst) begin
            req_ready       = w_req_ready;
            wb_ready        = w_wb_ready;
            rf_register     = riscv_rf_pkg::zext_idx(w_port_idx);
            rf_write_enable = w_port_we;
            rf_write_data   = w_port_wdata;
        end
    end

    assign op_valid = (state_q == VALID);
    assign op_a     = op_a_q;
    assign op_b     = op_b_q;

    // State, latched indices and captured operands
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            rs1_q   <= '0;
            rs2_q   <= '0;
            op_a_q  <= '0;
            op_b_q  <= '0;
        end else begin
            state_q <= state_d;
            rs1_q   <= rs1_d;
            rs2_q   <= rs2_d;
            op_a_q  <= op_a_d;
            op_b_q  <= op_b_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_regfile_port_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_port_sequencer
// Description : Directed self-checking bench for regfile_port_sequencer with
//               a behavioural single-port register file attached to its port.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_port_sequencer;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [4:0]  req_rs1;
    logic [4:0]  req_rs2;
    logic        op_valid;
    logic        op_ready;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        wb_valid;
    logic        wb_ready;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic [31:0] rf_register;
    logic        rf_write_enable;
    logic [31:0] rf_write_data;
    logic [31:0] rf_read_data;

    int errors = 0;
    int checks = 0;

    logic [31:0] mem [32];

    regfile_port_sequencer #(.XLEN(32), .AW(5)) dut (
        .clk             (clk),
        .rst             (rst),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_rs1         (req_rs1),
        .req_rs2         (req_rs2),
        .op_valid        (op_valid),
        .op_ready        (op_ready),
        .op_a            (op_a),
        .op_b            (op_b),
        .wb_valid        (wb_valid),
        .wb_ready        (wb_ready),
        .wb_rd           (wb_rd),
        .wb_data         (wb_data),
        .rf_register     (rf_register),
        .rf_write_enable (rf_write_enable),
        .rf_write_data   (rf_write_data),
        .rf_read_data    (rf_read_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural register file: x0 hard-wired to zero, combinational read
    assign rf_read_data = (rf_register[4:0] == 5'd0) ? 32'd0 : mem[rf_register[4:0]];
    always @(posedge clk) begin
        if (rf_write_enable && rf_register[4:0] != 5'd0)
            mem[rf_register[4:0]] <= rf_write_data;
    end

    // Stimulus helper: one writeback issued from IDLE
    task automatic wb_write(input logic [4:0] rd, input logic [31:0] data);
        @(negedge clk);
        wb_valid = 1'b1; wb_rd = rd; wb_data = data;
        @(posedge clk);
        @(negedge clk);
        wb_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (op_valid !== 1'b0) begin errors++; $display("FAIL reset_op_valid got=%b exp=0", op_valid); end
        checks++; if (op_a !== 32'd0) begin errors++; $display("FAIL reset_op_a got=%h exp=0", op_a); end
        checks++; if (op_b !== 32'd0) begin errors++; $display("FAIL reset_op_b got=%h exp=0", op_b); end
        checks++; if (req_ready !== 1'b0 || wb_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got=%b%b exp=00", req_ready, wb_ready); end
        checks++; if (rf_register !== 32'd0 || rf_write_enable !== 1'b0 || rf_write_data !== 32'd0) begin
            errors++; $display("FAIL reset_port got=%h/%b/%h exp=0/0/0", rf_register, rf_write_enable, rf_write_data); end
        rst = 1'b1;
    endtask

    task automatic test_basic_read;
        wb_write(5'd5, 32'hDEADBEEF);
        wb_write(5'd6, 32'h12345678);
        @(negedge clk);
        req_valid = 1'b1; req_rs1 = 5'd5; req_rs2 = 5'd6;
        #1;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL basic_req_ready got=%b exp=1", req_ready); end
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        checks++; if (op_valid !== 1'b0 || rf_register !== 32'd5) begin
            errors++; $display("FAIL basic_rd1 got=valid %b reg %h exp=0/5", op_valid, rf_register); end
        @(negedge clk);
        checks++; if (op_valid !== 1'b0 || rf_register !== 32'd6) begin
            errors++; $display("FAIL basic_rd2 got=valid %b reg %h exp=0/6", op_valid, rf_register); end
        @(negedge clk);
        checks++; if (op_valid !== 1'b1) begin errors++; $display("FAIL basic_op_valid got=%b exp=1", op_valid); end
        checks++; if (op_a !== 32'hDEADBEEF) begin errors++; $display("FAIL basic_op_a got=%h exp=deadbeef", op_a); end
        checks++; if (op_b !== 32'h12345678) begin errors++; $display("FAIL basic_op_b got=%h exp=12345678", op_b); end
        op_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        op_ready = 1'b0;
        checks++; if (op_valid !== 1'b0) begin errors++; $display("FAIL basic_release got=%b exp=0", op_valid); end
    endtask

    task automatic test_wb_priority;
        @(negedge clk);
        wb_valid = 1'b1; wb_rd = 5'd5; wb_data = 32'hCAFEF00D;
        req_valid = 1'b1; req_rs1 = 5'd5; req_rs2 = 5'd6;
        #1;
        checks++; if (wb_ready !== 1'b1 || req_ready !== 1'b0) begin
            errors++; $display("FAIL prio_ready got=wb %b req %b exp=1/0", wb_ready, req_ready); end
        @(posedge clk);
        @(negedge clk);
        wb_valid = 1'b0;
        #1;
        checks++; if (req_ready !== 1'b1 || wb_ready !== 1'b0) begin
            errors++; $display("FAIL prio_accept got=req %b wb %b exp=1/0", req_ready, wb_ready); end
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (op_valid !== 1'b1 || op_a !== 32'hCAFEF00D || op_b !== 32'h12345678) begin
            errors++; $display("FAIL prio_ops got=%b %h %h exp=1 cafef00d 12345678", op_valid, op_a, op_b); end
        op_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        op_ready = 1'b0;
    endtask

    task automatic test_x0;
        @(negedge clk);
        wb_valid = 1'b1; wb_rd = 5'd0; wb_data = 32'hFFFFFFFF;
        #1;
        checks++; if (wb_ready !== 1'b1 || rf_write_enable !== 1'b0) begin
            errors++; $display("FAIL x0_write got=wb_ready %b we %b exp=1/0", wb_ready, rf_write_enable); end
        @(posedge clk);
        @(negedge clk);
        wb_valid = 1'b0;
        req_valid = 1'b1; req_rs1 = 5'd0; req_rs2 = 5'd0;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            checks++; if (rf_write_enable !== 1'b0) begin errors++; $display("FAIL x0_we_read got=%b exp=0", rf_write_enable); end
            @(negedge clk);
        end
        checks++; if (op_valid !== 1'b1 || op_a !== 32'd0 || op_b !== 32'd0) begin
            errors++; $display("FAIL x0_ops got=%b %h %h exp=1 0 0", op_valid, op_a, op_b); end
        op_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        op_ready = 1'b0;
    endtask

    task automatic test_hold_valid;
        logic [31:0] val;
        wb_write(5'd7, 32'h11111111);
        wb_write(5'd8, 32'h22222222);
        @(negedge clk);
        req_valid = 1'b1; req_rs1 = 5'd7; req_rs2 = 5'd8;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            val = 32'hA0000000 + 32'(i);
            wb_valid = 1'b1; wb_rd = 5'd7; wb_data = val;
            #1;
            checks++; if (wb_ready !== 1'b1 || rf_write_enable !== 1'b1 || rf_register !== 32'd7 || rf_write_data !== val) begin
                errors++; $display("FAIL hold_wb%0d got=%b %b %h %h exp=1 1 7 %h", i, wb_ready, rf_write_enable, rf_register, rf_write_data, val); end
            checks++; if (op_valid !== 1'b1 || op_a !== 32'h11111111) begin
                errors++; $display("FAIL hold_ops%0d got=%b %h exp=1 11111111", i, op_valid, op_a); end
            @(posedge clk);
            @(negedge clk);
            checks++; if (mem[7] !== val) begin errors++; $display("FAIL hold_commit%0d got=%h exp=%h", i, mem[7], val); end
        end
        wb_valid = 1'b0;
        op_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        op_ready = 1'b0;
        checks++; if (op_valid !== 1'b0) begin errors++; $display("FAIL hold_release got=%b exp=0", op_valid); end
        req_valid = 1'b1; req_rs1 = 5'd7; req_rs2 = 5'd8;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (op_a !== 32'hA0000004 || op_b !== 32'h22222222) begin
            errors++; $display("FAIL hold_reread got=%h %h exp=a0000004 22222222", op_a, op_b); end
        op_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        op_ready = 1'b0;
    endtask

    task automatic test_wb_during_read;
        wb_write(5'd9, 32'h99990000);
        @(negedge clk);
        req_valid = 1'b1; req_rs1 = 5'd9; req_rs2 = 5'd5;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        wb_valid = 1'b1; wb_rd = 5'd9; wb_data = 32'hABCD0001;
        #1;
        checks++; if (wb_ready !== 1'b0 || rf_write_enable !== 1'b0 || rf_register !== 32'd9) begin
            errors++; $display("FAIL rdwb_rd1 got=%b %b %h exp=0 0 9", wb_ready, rf_write_enable, rf_register); end
        @(negedge clk);
        checks++; if (wb_ready !== 1'b0 || rf_write_enable !== 1'b0 || rf_register !== 32'd5) begin
            errors++; $display("FAIL rdwb_rd2 got=%b %b %h exp=0 0 5", wb_ready, rf_write_enable, rf_register); end
        checks++; if (mem[9] !== 32'h99990000) begin errors++; $display("FAIL rdwb_nowrite got=%h exp=99990000", mem[9]); end
        @(negedge clk);
        checks++; if (op_valid !== 1'b1 || op_a !== 32'h99990000 || op_b !== 32'hCAFEF00D) begin
            errors++; $display("FAIL rdwb_ops got=%b %h %h exp=1 99990000 cafef00d", op_valid, op_a, op_b); end
        checks++; if (wb_ready !== 1'b1 || rf_write_enable !== 1'b1) begin
            errors++; $display("FAIL rdwb_valid_wb got=%b %b exp=1 1", wb_ready, rf_write_enable); end
        op_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        op_ready = 1'b0; wb_valid = 1'b0;
        checks++; if (mem[9] !== 32'hABCD0001) begin errors++; $display("FAIL rdwb_commit got=%h exp=abcd0001", mem[9]); end
    endtask

    task automatic test_reset_mid;
        @(negedge clk);
        req_valid = 1'b1; req_rs1 = 5'd5; req_rs2 = 5'd6;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        #1;
        rst = 1'b0;
        #1;
        checks++; if (op_valid !== 1'b0 || op_a !== 32'd0 || op_b !== 32'd0) begin
            errors++; $display("FAIL midrst_ops got=%b %h %h exp=0 0 0", op_valid, op_a, op_b); end
        checks++; if (rf_register !== 32'd0 || rf_write_enable !== 1'b0 || req_ready !== 1'b0 || wb_ready !== 1'b0) begin
            errors++; $display("FAIL midrst_port got=%h %b %b %b exp=0 0 0 0", rf_register, rf_write_enable, req_ready, wb_ready); end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        req_valid = 1'b1;
        #1;
        checks++; if (req_ready !== 1'b1 || op_valid !== 1'b0) begin
            errors++; $display("FAIL midrst_idle got=req_ready %b op_valid %b exp=1 0", req_ready, op_valid); end
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (op_valid !== 1'b1 || op_a !== 32'hCAFEF00D || op_b !== 32'h12345678) begin
            errors++; $display("FAIL midrst_reread got=%b %h %h exp=1 cafef00d 12345678", op_valid, op_a, op_b); end
        op_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        op_ready = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = 32'd0;
        rst = 1'b1; req_valid = 1'b0; req_rs1 = '0; req_rs2 = '0;
        op_ready = 1'b0; wb_valid = 1'b0; wb_rd = '0; wb_data = '0;
        test_reset;
        test_basic_read;
        test_wb_priority;
        test_x0;
        test_hold_valid;
        test_wb_during_read;
        test_reset_mid;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/regfile_port_sequencer.md
# regfile_port_sequencer

Front-end sequencer for the single-port register file: it owns the file's only port (one shared register index, write enable, write data, combinational read data). It turns a two-operand read request (rs1, rs2) into two back-to-back port reads and merges writeback traffic into idle port cycles. Downstream it presents both operands together under a valid/ready handshake to the execute stage.

## Interface
Parameters:
- XLEN, 32, data width; must match the register file.
- AW, 5, register index width; indices are zero-extended to 32 bits on rf_register.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset; 0 forces reset immediately, independent of clk.
- req_valid  in  1  operand read request present.
- req_ready  out  1  request accepted this cycle.
- req_rs1  in  AW  first source index.
- req_rs2  in  AW  second source index.
- op_valid  out  1  op_a/op_b valid.
- op_ready  in  1  consumer takes operands.
- op_a  out  XLEN  value of rs1.
- op_b  out  XLEN  value of rs2.
- wb_valid  in  1  writeback request present.
- wb_ready  out  1  writeback performed this cycle.
- wb_rd  in  AW  destination index.
- wb_data  in  XLEN  writeback value.
- rf_register  out  32  register file index, {zeros, index}.
- rf_write_enable  out  1  register file write enable.
- rf_write_data  out  XLEN  register file write data.
- rf_read_data  in  XLEN  register file combinational read data.

## Operation
- FSM states: IDLE, RD1, RD2, VALID.
- IDLE: if wb_valid, perform the write (rf_register=wb_rd, rf_write_data=wb_data, rf_write_enable=1 unless wb_rd==0), wb_ready=1, req_ready=0, stay in IDLE. Else if req_valid: req_ready=1, latch rs1/rs2, go to RD1. Writeback therefore has priority over new requests.
- RD1: rf_register=rs1_q, rf_write_enable=0; op_a captures rf_read_data on the edge; go to RD2. wb_ready=0, req_ready=0.
- RD2: same for rs2_q into op_b; go to VALID.
- VALID: op_valid=1, op_a/op_b are stable. The port is free, so any pending writeback is performed exactly as in IDLE (wb_ready=1). When op_ready=1, go to IDLE. req_ready=0.
- Ordering: an accepted request observes every write whose wb_ready was asserted in an earlier cycle, and no later write.
- Writes to x0: wb_ready=1 and the write is consumed, but rf_write_enable=0. x0 reads return 0 because the register file forces them.
- Idle port: rf_register=0, rf_write_enable=0, rf_write_data=0.

## Timing
- Reset values: state=IDLE; op_valid=0, op_a=0, op_b=0, req_ready=0, wb_ready=0, rf_write_enable=0, rf_register=0, rf_write_data=0.
- req_ready and wb_ready are combinational from state and the valid inputs. They are never both 1 in the same cycle.
- Request accepted at edge N, op_valid=1 from cycle N+3. Throughput is at most one request per 4 cycles when op_ready is held high.
- A write in IDLE or VALID commits at the same clk edge that samples wb_ready=1.
- Reset mid-operation (any state) drops the in-flight request and its operands; register file contents are not touched.
- op_valid is never withdrawn without op_ready; op_a/op_b do not change while op_valid=1.

## Structure
- Shared package riscv_rf_pkg holds XLEN, AW, the state enum (IDLE, RD1, RD2, VALID) and the index zero-extension function.
- Single module, with no sub-module. The register file is instantiated beside it at the datapath level, not inside it.

## Test plan
- Reset, then write x5=0xDEADBEEF and x6=0x12345678 via wb, then request rs1=5, rs2=6 -> op_valid at accept+3 with op_a=0xDEADBEEF, op_b=0x12345678.
- wb_valid and req_valid asserted together in IDLE -> wb_ready=1, req_ready=0 for that cycle. The request is accepted the next cycle and sees the new value.
- Write x0=0xFFFFFFFF, then read rs1=0, rs2=0 -> rf_write_enable stays 0 throughout; op_a=op_b=0.
- Hold op_ready=0 for 5 cycles in VALID while issuing writebacks to rs1 -> each write is performed, op_a is unchanged, and op_valid stays 1 until op_ready.
- Assert rst low in RD2 -> all outputs are 0 immediately. After release the FSM is in IDLE, and earlier register contents are still readable.
- wb_valid asserted during RD1/RD2 -> wb_ready=0 and no write occurs until VALID.
